// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encodings, the x0 register index and the load-use match helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_FLUSH    = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic lu_match(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2,
        input logic [4:0] rd,
        input logic       ld
    );
        return ld && (rd != REG_ZERO) &&
               ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
// Ports: clk, reset (async active-low), inc, cnt[W-1:0].
module hz_sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, mem wait, redirect.
// Ports: ID/EX hazard inputs, mem handshake -> stall/flush enables, mem_err, perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall1,
    output logic             stall2,
    output logic             branch,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             exmem_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int LW = $clog2(LU_CYCLES + 1);
    localparam logic [WW-1:0] TO_V    = WW'(MEM_TIMEOUT);
    localparam logic [LW-1:0] LU_INIT = LW'(LU_CYCLES - 1);

    hz_state_t       state, state_n;
    logic [LW-1:0]   lu_cnt, lu_cnt_n;
    logic [WW-1:0]   wait_cnt, wait_cnt_n;
    logic            pend_flush, pend_n;
    logic            err_n;
    logic            lu_hit;

    assign lu_hit = lu_match(id_rs1, id_rs2, id_use_rs1,
                             id_use_rs2, ex_rd, ex_mem_read);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HZ_RUN;
            lu_cnt     <= '0;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_n;
            lu_cnt     <= lu_cnt_n;
            wait_cnt   <= wait_cnt_n;
            pend_flush <= pend_n;
            mem_err    <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        lu_cnt_n   = lu_cnt;
        wait_cnt_n = wait_cnt;
        pend_n     = pend_flush;
        err_n      = mem_err;
        stall1     = 1'b0;
        stall2     = 1'b0;
        branch     = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        exmem_hold = 1'b0;
        // Outputs stay idle while reset is held, whatever the inputs do.
        if (reset) begin
            unique case (state)
                HZ_RUN: begin
                    if (mem_req && !mem_ready) begin
                        stall2     = 1'b1;
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        exmem_hold = 1'b1;
                        if (ex_redirect) pend_n = 1'b1;
                        state_n    = HZ_MEM_WAIT;
                        wait_cnt_n = WW'(1);
                    end else if (ex_redirect) begin
                        branch     = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (lu_hit) begin
                        stall1  = 1'b1;
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        if (LU_CYCLES > 1) begin
                            state_n  = HZ_LU_STALL;
                            lu_cnt_n = LU_INIT;
                        end
                    end
                end
                HZ_LU_STALL: begin
                    if (ex_redirect) begin
                        branch     = 1'b1;
                        ifid_flush = 1'b1;
                        state_n    = HZ_RUN;
                        lu_cnt_n   = '0;
                    end else begin
                        stall1  = 1'b1;
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        if (lu_cnt <= LW'(1)) begin
                            state_n  = HZ_RUN;
                            lu_cnt_n = '0;
                        end else begin
                            lu_cnt_n = lu_cnt - 1'b1;
                        end
                    end
                end
                HZ_MEM_WAIT: begin
                    // Ready or timeout both release the stall this cycle.
                    if (mem_ready || wait_cnt >= TO_V) begin
                        if (!mem_ready) err_n = 1'b1;
                        state_n    = pend_flush ? HZ_FLUSH : HZ_RUN;
                        wait_cnt_n = '0;
                    end else begin
                        stall2     = 1'b1;
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        exmem_hold = 1'b1;
                        wait_cnt_n = wait_cnt + 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    branch     = 1'b1;
                    ifid_flush = 1'b1;
                    pend_n     = 1'b0;
                    state_n    = HZ_RUN;
                end
                default: state_n = HZ_RUN;
            endcase
        end
    end

    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall1 | stall2),
        .cnt   (stall_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch),
        .cnt   (flush_cnt)
    );

endmodule
